// File: rtl/audio_voice_mixer_if.sv
// Voice mixer bus: per-voice inputs toward the mixer, mixed sample back out.
interface audio_voice_mixer_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned VOL_BITS   = 4
);
    logic                           ena;
    logic [12*NUM_VOICES-1:0]       voices;
    logic [VOL_BITS*NUM_VOICES-1:0] volumes;
    logic [NUM_VOICES-1:0]          mutes;
    logic [11:0]                    audio;
    logic                           sample_valid;
    logic                           clip;

    modport master (
        output ena, voices, volumes, mutes,
        input  audio, sample_valid, clip
    );

    modport slave (
        input  ena, voices, volumes, mutes,
        output audio, sample_valid, clip
    );
endinterface

// File: rtl/audio_voice_mixer.sv
// Per-sample snapshot of NUM_VOICES signed voices, serial multiply-accumulate,
// then scale/saturate into a 12-bit offset-binary sample for the PWM stage.
module audio_voice_mixer #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_DIV = 272,
    parameter int unsigned VOL_BITS   = 4
) (
    input logic               clk,
    input logic               rst,
    audio_voice_mixer_if.slave bus
);
    localparam int unsigned AccW = 12 + VOL_BITS + $clog2(NUM_VOICES);
    localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned TmrW = $clog2(SAMPLE_DIV);

    localparam logic [TmrW-1:0]        TmrLoad = TmrW'(SAMPLE_DIV - 1);
    localparam logic [IdxW-1:0]        IdxLast = IdxW'(NUM_VOICES - 1);
    localparam logic signed [AccW-1:0] SatMax  = AccW'(2047);
    localparam logic signed [AccW-1:0] SatMin  = ~SatMax;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccum  = 2'd1;
    localparam logic [1:0] StOutput = 2'd2;

    if (NUM_VOICES < 1 || NUM_VOICES > 8) begin : g_bad_voices
        $error("audio_voice_mixer: NUM_VOICES must be in 1..8");
    end
    if (SAMPLE_DIV < NUM_VOICES + 3) begin : g_bad_div
        $error("audio_voice_mixer: SAMPLE_DIV must be >= NUM_VOICES+3");
    end

    logic [TmrW-1:0]                timer_q;
    logic [1:0]                     state_q;
    logic [IdxW-1:0]                idx_q;
    logic signed [AccW-1:0]         acc_q;
    logic [12*NUM_VOICES-1:0]       voices_q;
    logic [VOL_BITS*NUM_VOICES-1:0] volumes_q;
    logic [NUM_VOICES-1:0]          mutes_q;
    logic [11:0]                    audio_q;
    logic                           valid_q;
    logic                           clip_q;

    logic                   strobe;
    logic [11:0]            cur_voice;
    logic [VOL_BITS-1:0]    cur_vol;
    logic signed [AccW-1:0] voice_ext;
    logic signed [AccW-1:0] vol_ext;
    logic signed [AccW-1:0] product;
    logic signed [AccW-1:0] shifted;
    logic                   sat_hi;
    logic                   sat_lo;
    logic [11:0]            sat_val;

    assign strobe = bus.ena && (timer_q == '0);

    always_comb begin
        cur_voice = voices_q[32'(idx_q) * 12 +: 12];
        cur_vol   = volumes_q[32'(idx_q) * VOL_BITS +: VOL_BITS];
        voice_ext = {{(AccW - 12){cur_voice[11]}}, cur_voice};
        vol_ext   = {{(AccW - VOL_BITS){1'b0}}, cur_vol};
        // True product fits in 12+VOL_BITS bits, so truncation to AccW is exact.
        product   = mutes_q[idx_q] ? '0 : voice_ext * vol_ext;
    end

    always_comb begin
        shifted = acc_q >>> VOL_BITS;
        sat_hi  = shifted > SatMax;
        sat_lo  = shifted < SatMin;
        if (sat_hi) begin
            sat_val = 12'h7FF;
        end else if (sat_lo) begin
            sat_val = 12'h800;
        end else begin
            sat_val = shifted[11:0];
        end
    end

    // Snapshot registers need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (!rst && bus.ena && state_q == StIdle && strobe) begin
            voices_q  <= bus.voices;
            volumes_q <= bus.volumes;
            mutes_q   <= bus.mutes;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= TmrLoad;
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            audio_q <= 12'h800;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.ena) begin
                timer_q <= strobe ? TmrLoad : timer_q - 1'b1;
                case (state_q)
                    StIdle: begin
                        if (strobe) begin
                            acc_q   <= '0;
                            idx_q   <= '0;
                            state_q <= StAccum;
                        end
                    end
                    StAccum: begin
                        acc_q <= acc_q + product;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == IdxLast) begin
                            state_q <= StOutput;
                        end
                    end
                    StOutput: begin
                        audio_q <= {~sat_val[11], sat_val[10:0]};
                        clip_q  <= sat_hi | sat_lo;
                        valid_q <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.audio        = audio_q;
    assign bus.sample_valid = valid_q;
    assign bus.clip         = clip_q;
endmodule

// File: tb/tb_audio_voice_mixer.sv
// Bench for audio_voice_mixer: a default-rate instance for reset/latency and a
// fast SAMPLE_DIV=8 instance for mixing, timing, capture and abort scenarios.
module tb_audio_voice_mixer;
    localparam int N  = 4;
    localparam int VB = 4;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    audio_voice_mixer_if #(.NUM_VOICES(N), .VOL_BITS(VB)) ifa ();
    audio_voice_mixer_if #(.NUM_VOICES(N), .VOL_BITS(VB)) ifb ();

    audio_voice_mixer #(.NUM_VOICES(N), .SAMPLE_DIV(272), .VOL_BITS(VB)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    audio_voice_mixer #(.NUM_VOICES(N), .SAMPLE_DIV(8), .VOL_BITS(VB)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    int checks   = 0;
    int failures = 0;

    int v   [N];
    int vol [N];
    bit m   [N];

    task automatic apply_b();
        for (int i = 0; i < N; i++) begin
            ifb.voices[12*i +: 12]  = 12'(v[i]);
            ifb.volumes[VB*i +: VB] = VB'(vol[i]);
            ifb.mutes[i]            = m[i];
        end
    endtask

    // Reference: sum of unmuted voice*volume, floor-divide by 2^VB, clamp, offset.
    function automatic void model(output logic [11:0] a, output logic c);
        int sum;
        int s;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            if (!m[i]) sum += v[i] * vol[i];
        end
        s = sum >>> VB;
        c = (s > 2047) || (s < -2048);
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        a = 12'(s + 2048);
    endfunction

    task automatic wait_pulse_b(input int limit, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            @(posedge clk); #1;
            n++;
            got = ifb.sample_valid;
        end
    endtask

    // Second pulse is guaranteed to come from a capture after the inputs changed.
    task automatic sample_b(output logic [11:0] a, output logic c, output bit ok);
        int n;
        bit g1;
        bit g2;
        wait_pulse_b(40, n, g1);
        wait_pulse_b(40, n, g2);
        ok = g1 && g2;
        a  = ifb.audio;
        c  = ifb.clip;
    endtask

    task automatic test_reset();
        int  n;
        bit  got;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.ena = 1'b1;
        ifb.ena = 1'b1;
        ifa.voices = '0;
        ifb.voices = '0;
        ifa.volumes = {N{4'hF}};
        ifb.volumes = {N{4'hF}};
        ifa.mutes = '0;
        ifb.mutes = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ifa.audio !== 12'h800 || ifa.sample_valid !== 1'b0 || ifa.clip !== 1'b0) begin
                failures++;
                $display("FAIL reset_state_a: audio=%h valid=%b clip=%b, want 800/0/0",
                         ifa.audio, ifa.sample_valid, ifa.clip);
            end
        end
        checks++;
        if (ifb.audio !== 12'h800 || ifb.sample_valid !== 1'b0 || ifb.clip !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_b: audio=%h valid=%b clip=%b, want 800/0/0",
                     ifb.audio, ifb.sample_valid, ifb.clip);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(posedge clk); #1;
            n++;
            got = ifa.sample_valid;
        end
        checks++;
        if (!got || n != 277) begin
            failures++;
            $display("FAIL first_pulse_latency: got=%b cycles=%0d, want 277", got, n);
        end
        checks++;
        if (ifa.audio !== 12'h800 || ifa.clip !== 1'b0) begin
            failures++;
            $display("FAIL first_sample_silence: audio=%h clip=%b, want 800/0", ifa.audio, ifa.clip);
        end
        @(posedge clk); #1;
        checks++;
        if (ifa.sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_pulse_width: valid=%b one cycle later, want 0", ifa.sample_valid);
        end
    endtask

    task automatic test_directed();
        int          dv   [6][4];
        int          dvol [6][4];
        int          dm   [6];
        logic [11:0] ea   [6];
        logic        ec   [6];
        logic [11:0] a;
        logic        c;
        bit          ok;
        dv   = '{'{1000, 123, -77, 2047}, '{-1, 500, 0, 0}, '{2047, 2047, 2047, 2047},
                 '{-2048, -2048, -2048, -2048}, '{0, 0, 0, 0}, '{512, -256, 100, 0}};
        dvol = '{'{15, 9, 3, 15}, '{1, 15, 0, 0}, '{15, 15, 15, 15},
                 '{15, 15, 15, 15}, '{15, 15, 15, 15}, '{8, 4, 15, 7}};
        dm   = '{4'b1110, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        ea   = '{12'hBA9, 12'h7FF, 12'hFFF, 12'h000, 12'h800, 12'h8C0};
        ec   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) begin
                v[i]   = dv[k][i];
                vol[i] = dvol[k][i];
                m[i]   = dm[k][i];
            end
            apply_b();
            sample_b(a, c, ok);
            checks++;
            if (!ok || a !== ea[k]) begin
                failures++;
                $display("FAIL directed_audio[%0d]: got=%h (pulse=%b), want %h", k, a, ok, ea[k]);
            end
            checks++;
            if (c !== ec[k]) begin
                failures++;
                $display("FAIL directed_clip[%0d]: got=%b, want %b", k, c, ec[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic        c;
        logic [11:0] ea;
        logic        ec;
        bit          ok;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin
                v[i]   = int'($urandom_range(0, 4095)) - 2048;
                vol[i] = int'($urandom_range(0, 15));
                m[i]   = ($urandom_range(0, 3) == 0);
            end
            // Bias some samples toward full scale to exercise saturation.
            if (k % 4 == 3) begin
                for (int i = 0; i < N; i++) begin
                    v[i]   = (k % 8 == 3) ? 2000 : -2000;
                    vol[i] = 15;
                    m[i]   = 1'b0;
                end
            end
            apply_b();
            model(ea, ec);
            sample_b(a, c, ok);
            checks++;
            if (!ok || a !== ea) begin
                failures++;
                $display("FAIL random_audio[%0d]: got=%h (pulse=%b), want %h", k, a, ok, ea);
            end
            checks++;
            if (c !== ec) begin
                failures++;
                $display("FAIL random_clip[%0d]: got=%b, want %b", k, c, ec);
            end
        end
    endtask

    task automatic test_period();
        int n;
        bit got;
        int idx [3];
        int cnt;
        int run;
        int t;
        bit wide;
        ifb.ena = 1'b1;
        wait_pulse_b(40, n, got);
        wait_pulse_b(40, n, got);
        checks++;
        if (!got || n != 8) begin
            failures++;
            $display("FAIL period_ena_high: got=%b cycles=%0d, want 8", got, n);
        end
        cnt  = 0;
        run  = 0;
        t    = 0;
        wide = 1'b0;
        while (cnt < 3 && t < 100) begin
            ifb.ena = ~ifb.ena;
            @(posedge clk); #1;
            t++;
            if (ifb.sample_valid) begin
                if (run == 0) begin
                    idx[cnt] = t;
                    cnt++;
                end
                run++;
                if (run > 1) wide = 1'b1;
            end else begin
                run = 0;
            end
        end
        ifb.ena = 1'b1;
        checks++;
        if (cnt != 3 || idx[1] - idx[0] != 16 || idx[2] - idx[1] != 16) begin
            failures++;
            $display("FAIL period_ena_toggle: pulses=%0d gaps=%0d,%0d, want 3 pulses gaps 16,16",
                     cnt, idx[1] - idx[0], idx[2] - idx[1]);
        end
        checks++;
        if (wide) begin
            failures++;
            $display("FAIL pulse_width_toggle: pulse longer than 1 cycle, want 1");
        end
    endtask

    task automatic test_capture();
        logic [11:0] ea1;
        logic [11:0] ea2;
        logic        ec;
        logic [11:0] a;
        bit          ok;
        logic        c;
        int          n;
        bit          got;
        for (int i = 0; i < N; i++) begin
            v[i] = 300 * (i + 1);
            vol[i] = 15;
            m[i] = (i != 0);
        end
        v[0] = 1000;
        apply_b();
        model(ea1, ec);
        sample_b(a, c, ok);
        // Capture edge of the next sample is 3 edges after this pulse.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        v[0] = -1000;
        apply_b();
        model(ea2, ec);
        wait_pulse_b(40, n, got);
        checks++;
        if (!got || n != 5 || ifb.audio !== ea1) begin
            failures++;
            $display("FAIL capture_inflight: audio=%h cycles=%0d, want %h after 5", ifb.audio, n, ea1);
        end
        wait_pulse_b(40, n, got);
        checks++;
        if (!got || ifb.audio !== ea2) begin
            failures++;
            $display("FAIL capture_next: audio=%h (pulse=%b), want %h", ifb.audio, got, ea2);
        end
    endtask

    task automatic test_reset_abort();
        logic [11:0] ea;
        logic        ec;
        logic [11:0] a;
        logic        c;
        bit          ok;
        int          n;
        bit          got;
        for (int i = 0; i < N; i++) begin
            v[i] = 1000;
            vol[i] = 15;
            m[i] = (i != 0);
        end
        apply_b();
        model(ea, ec);
        sample_b(a, c, ok);
        checks++;
        if (!ok || a !== ea) begin
            failures++;
            $display("FAIL abort_setup: audio=%h (pulse=%b), want %h", a, ok, ea);
        end
        // Pulse edge P, capture at P+3, E2 at P+5.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        checks++;
        if (ifb.audio !== 12'h800 || ifb.sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: audio=%h valid=%b, want 800/0", ifb.audio, ifb.sample_valid);
        end
        wait_pulse_b(40, n, got);
        checks++;
        if (!got || n != 13) begin
            failures++;
            $display("FAIL abort_restart: got=%b cycles=%0d, want 13", got, n);
        end
        checks++;
        if (ifb.audio !== ea) begin
            failures++;
            $display("FAIL abort_next_sample: audio=%h, want %h", ifb.audio, ea);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_period();
        test_capture();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
